// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode encodings,
// depth derivation and a parameter sanity check used at elaboration.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Number of words held by a FIFO with the given address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // True when the parameter set describes a buildable FIFO.
  function automatic bit fifo_params_ok(input int data_width, input int addr_width,
                                        input int fwft, input int af_level,
                                        input int ae_level);
    int depth;
    depth = 1 << addr_width;
    return (data_width >= 1) &&
           (addr_width >= 1) && (addr_width <= 12) &&
           ((fwft == FIFO_MODE_STD) || (fwft == FIFO_MODE_FWFT)) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one registered write port, one asynchronous
// read port. Contents are deliberately left unreset.
module fifo_ram #(
  parameter int DATAWIDTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATAWIDTH-1:0]  i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATAWIDTH-1:0]  o_rdata
);

  logic [DATAWIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];

  // Write port: store the word on an accepted write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact fill count, programmable almost-full/empty
// thresholds, standard or first-word-fall-through read, and sticky
// overflow/underflow error flags.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATAWIDTH-1:0]  i_wdata,
  input  logic                  i_winc,
  input  logic                  i_rinc,
  input  logic                  i_clr_err,
  output logic [DATAWIDTH-1:0]  o_rdata,
  output logic                  o_rvalid,
  output logic                  o_wfull,
  output logic                  o_rempty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] LP_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

  if (!fifo_params_ok(DATAWIDTH, ADDR_WIDTH, FWFT, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_flags: illegal parameter combination");
  end

  logic [ADDR_WIDTH:0]  r_wptr, r_rptr, r_count;
  logic [ADDR_WIDTH:0]  w_wptr_next, w_rptr_next, w_count_next;
  logic                 r_empty, r_full, r_af, r_ae, r_ovf, r_udf;
  logic                 w_rd_acc, w_wr_acc;
  logic [DATAWIDTH-1:0] w_ram_rdata;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd_acc = i_rinc & ~r_empty;
  assign w_wr_acc = i_winc & (~r_full | w_rd_acc);

  assign w_wptr_next  = r_wptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
  assign w_rptr_next  = r_rptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
  // Pointers run modulo 2*DEPTH, so their difference is the exact fill level
  // (identical to count + wr_acc - rd_acc).
  assign w_count_next = w_wptr_next - w_rptr_next;

  fifo_ram #(
    .DATAWIDTH (DATAWIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_wr_acc),
    .i_waddr(r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata(i_wdata),
    .i_raddr(r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata(w_ram_rdata)
  );

  // Pointers, count and status flags, all registered from the next count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_af    <= (LP_AF == '0);
      r_ae    <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_next;
      r_rptr  <= w_rptr_next;
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == LP_DEPTH);
      r_af    <= (w_count_next >= LP_AF);
      r_ae    <= (w_count_next <= LP_AE);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (i_winc & ~w_wr_acc) | (r_ovf & ~i_clr_err);
      r_udf <= (i_rinc & ~w_rd_acc) | (r_udf & ~i_clr_err);
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is presented directly; masked to zero while empty.
    assign o_rdata  = r_empty ? '0 : w_ram_rdata;
    assign o_rvalid = ~r_empty;
  end else begin : g_std
    logic [DATAWIDTH-1:0] r_rdata;
    logic                 r_rvalid;

    // Output register: captures the head word on each accepted read.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_rd_acc;
        if (w_rd_acc) begin
          r_rdata <= w_ram_rdata;
        end
      end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
  end

  assign o_count        = r_count;
  assign o_rempty       = r_empty;
  assign o_wfull        = r_full;
  assign o_almost_full  = r_af;
  assign o_almost_empty = r_ae;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode instance checked against a
// queue-based model, plus a directed check of a first-word-fall-through instance.
module tb_sync_fifo_flags;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic       rst, winc, rinc, clr_err;
  logic [7:0] wdata, rdata;
  logic       rvalid, wfull, rempty, afull, aempty, ovf, udf;
  logic [3:0] count;
  logic [10:0] st;
  assign st = {count, rempty, wfull, afull, aempty, ovf, udf, rvalid};

  sync_fifo_flags #(.DATAWIDTH(8), .ADDR_WIDTH(3), .FWFT(0)) u_std (
    .i_clk(clk), .i_rst(rst), .i_wdata(wdata), .i_winc(winc), .i_rinc(rinc),
    .i_clr_err(clr_err), .o_rdata(rdata), .o_rvalid(rvalid), .o_wfull(wfull),
    .o_rempty(rempty), .o_almost_full(afull), .o_almost_empty(aempty),
    .o_count(count), .o_overflow(ovf), .o_underflow(udf)
  );

  // FWFT instance
  logic       b_rst, b_winc, b_rinc, b_clr_err;
  logic [7:0] b_wdata, b_rdata;
  logic       b_rvalid, b_wfull, b_rempty, b_afull, b_aempty, b_ovf, b_udf;
  logic [3:0] b_count;

  sync_fifo_flags #(.DATAWIDTH(8), .ADDR_WIDTH(3), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst(b_rst), .i_wdata(b_wdata), .i_winc(b_winc), .i_rinc(b_rinc),
    .i_clr_err(b_clr_err), .o_rdata(b_rdata), .o_rvalid(b_rvalid), .o_wfull(b_wfull),
    .o_rempty(b_rempty), .o_almost_full(b_afull), .o_almost_empty(b_aempty),
    .o_count(b_count), .o_overflow(b_ovf), .o_underflow(b_udf)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: ordered word list plus expected output state.
  logic [7:0] m_q[$];
  logic [7:0] m_rdata = 8'h00;
  logic       m_rvalid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  function automatic logic [10:0] exp_status();
    int n;
    n = m_q.size();
    return {4'(n), n == 0, n == DEPTH, n >= DEPTH - 1, n <= 1, m_ovf, m_udf, m_rvalid};
  endfunction

  // One clock on the standard instance, then advance the model.
  task automatic tick(input logic w, input logic r, input logic [7:0] d,
                      input logic c, input logic rs);
    logic rd, wr;
    winc = w; rinc = r; wdata = d; clr_err = c; rst = rs;
    @(posedge clk); #1;
    if (rs) begin
      m_q.delete();
      m_rdata = 8'h00; m_rvalid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      rd = r && (m_q.size() != 0);
      wr = w && ((m_q.size() < DEPTH) || rd);
      m_rvalid = rd;
      if (rd) m_rdata = m_q.pop_front();
      if (wr) m_q.push_back(d);
      m_ovf = (w && !wr) || (m_ovf && !c);
      m_udf = (r && !rd) || (m_udf && !c);
    end
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic btick(input logic w, input logic r, input logic [7:0] d, input logic rs);
    b_winc = w; b_rinc = r; b_wdata = d; b_rst = rs; b_clr_err = 1'b0;
    @(posedge clk); #1;
    b_winc = 1'b0; b_rinc = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    checks++;
    if (st !== 11'b0000_1_0_0_1_0_0_0)
      $display("FAIL reset_status: got %b expected %b", st, 11'b0000_1_0_0_1_0_0_0);
    checks++;
    if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", rdata);
    if (rdata !== 8'h00) failures++;
    if (st !== 11'b0000_1_0_0_1_0_0_0) failures++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
      checks++;
      if (st !== exp_status()) begin
        failures++;
        $display("FAIL fill_status[%0d]: got %b expected %b", i, st, exp_status());
      end
      if (i == 6) begin
        checks++;
        if (afull !== 1'b1 || count !== 4'd7 || wfull !== 1'b0) begin
          failures++;
          $display("FAIL fill_af_at_7: got af=%b cnt=%0d full=%b expected af=1 cnt=7 full=0",
                   afull, count, wfull);
        end
      end
    end
    checks++;
    if (wfull !== 1'b1 || count !== 4'd8) begin
      failures++;
      $display("FAIL fill_full: got full=%b cnt=%0d expected full=1 cnt=8", wfull, count);
    end
    tick(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1 || count !== 4'd8) begin
      failures++;
      $display("FAIL fill_overflow: got ovf=%b cnt=%0d expected ovf=1 cnt=8", ovf, count);
    end
  endtask

  task automatic test_full_rw();
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL clr_overflow: got %b expected 0", ovf);
    end
    tick(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    checks++;
    if ({count, wfull, ovf, rvalid, rdata} !== {4'd8, 1'b1, 1'b0, 1'b1, 8'h11}) begin
      failures++;
      $display("FAIL full_rw: got cnt=%0d full=%b ovf=%b rv=%b rd=%h expected 8 1 0 1 11",
               count, wfull, ovf, rvalid, rdata);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checks++;
      if (st !== exp_status() || rdata !== m_rdata) begin
        failures++;
        $display("FAIL drain[%0d]: got st=%b rd=%h expected st=%b rd=%h",
                 i, st, rdata, exp_status(), m_rdata);
      end
    end
    checks++;
    if (rdata !== 8'h99 || rempty !== 1'b1) begin
      failures++;
      $display("FAIL drain_last: got rd=%h empty=%b expected rd=99 empty=1", rdata, rempty);
    end
  endtask

  task automatic test_empty_rw();
    tick(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    checks++;
    if (udf !== 1'b1 || count !== 4'd1 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL empty_rw: got udf=%b cnt=%0d rv=%b expected udf=1 cnt=1 rv=0",
               udf, count, rvalid);
    end
    tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({rdata, rvalid, rempty, aempty} !== {8'h5A, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL empty_rw_read: got rd=%h rv=%b empty=%b ae=%b expected 5a 1 1 1",
               rdata, rvalid, rempty, aempty);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 8'h5A) begin
      failures++;
      $display("FAIL rdata_hold: got rv=%b rd=%h expected rv=0 rd=5a", rvalid, rdata);
    end
  endtask

  task automatic test_clr_err();
    tick(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    checks++;
    if (udf !== 1'b1) begin
      failures++;
      $display("FAIL clr_vs_set: got udf=%b expected 1", udf);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (udf !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL clr_only: got udf=%b ovf=%b expected 0 0", udf, ovf);
    end
  endtask

  task automatic test_wrap();
    logic w, r, c;
    for (int i = 0; i < 80; i++) begin
      w = ($urandom_range(0, 99) < ((i < 40) ? 70 : 30));
      r = ($urandom_range(0, 99) < ((i < 40) ? 40 : 70));
      c = ($urandom_range(0, 15) == 0);
      tick(w, r, 8'($urandom), c, 1'b0);
      checks++;
      if (st !== exp_status() || (m_rvalid && rdata !== m_rdata)) begin
        failures++;
        $display("FAIL wrap[%0d]: got st=%b rd=%h expected st=%b rd=%h",
                 i, st, rdata, exp_status(), m_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    checks++;
    if (count !== 4'd5 || udf !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got cnt=%0d udf=%b expected 5 1", count, udf);
    end
    tick(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    checks++;
    if (st !== 11'b0000_1_0_0_1_0_0_0) begin
      failures++;
      $display("FAIL mid_reset: got %b expected %b", st, 11'b0000_1_0_0_1_0_0_0);
    end
    tick(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (rdata !== 8'h3C || rempty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_read: got rd=%h empty=%b expected 3c 1", rdata, rempty);
    end
  endtask

  task automatic test_fwft();
    btick(1'b1, 1'b0, 8'h12, 1'b1);
    checks++;
    if ({b_rdata, b_rvalid, b_rempty, b_count} !== {8'h00, 1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL fwft_reset: got rd=%h rv=%b empty=%b cnt=%0d expected 00 0 1 0",
               b_rdata, b_rvalid, b_rempty, b_count);
    end
    btick(1'b1, 1'b0, 8'hA5, 1'b0);
    checks++;
    if ({b_rdata, b_rvalid, b_rempty, b_count} !== {8'hA5, 1'b1, 1'b0, 4'd1}) begin
      failures++;
      $display("FAIL fwft_first_word: got rd=%h rv=%b empty=%b cnt=%0d expected a5 1 0 1",
               b_rdata, b_rvalid, b_rempty, b_count);
    end
    btick(1'b1, 1'b1, 8'h3C, 1'b0);
    checks++;
    if (b_rdata !== 8'h3C || b_count !== 4'd1) begin
      failures++;
      $display("FAIL fwft_pop_push: got rd=%h cnt=%0d expected 3c 1", b_rdata, b_count);
    end
    btick(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({b_rempty, b_rvalid, b_count, b_udf} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL fwft_pop: got empty=%b rv=%b cnt=%0d udf=%b expected 1 0 0 0",
               b_rempty, b_rvalid, b_count, b_udf);
    end
    btick(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (b_udf !== 1'b1) begin
      failures++;
      $display("FAIL fwft_underflow: got %b expected 1", b_udf);
    end
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    b_rst = 1'b1; b_winc = 1'b0; b_rinc = 1'b0; b_clr_err = 1'b0; b_wdata = 8'h00;
    test_reset();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_clr_err();
    test_wrap();
    test_reset_mid();
    test_fwft();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
